// File: rtl/vga_pkg.sv
// Shared video/game constants and projectile slot types.
package vga_pkg;

    // Slot count used by the weapon subsystem's projectile pool
    localparam int PROJECTILE_COUNT = 4;

    // Visible screen extents in pixels
    localparam int SCREEN_W_DEFAULT = 1024;
    localparam int SCREEN_H_DEFAULT = 768;

    // Signed 13-bit quantity: per-frame step component or a position
    // difference of two 12-bit screen coordinates
    typedef logic signed [12:0] step_t;

    // One projectile slot: occupancy, position and latched step vector
    typedef struct packed {
        logic        active;
        logic [11:0] x;
        logic [11:0] y;
        step_t       step_x;
        step_t       step_y;
    } proj_slot_t;

endpackage

// File: rtl/proj_aim_quant.sv
// Quantises an aim vector (dx, dy) to one of eight SPEED-scaled step vectors.
module proj_aim_quant
    import vga_pkg::*;
#(
    parameter int SPEED = 6
) (
    input  step_t dx,
    input  step_t dy,
    output step_t step_x,
    output step_t step_y
);

    localparam step_t SPD = step_t'(SPEED);

    logic [12:0] adx;
    logic [12:0] ady;

    // Signed component to -SPEED / 0 / +SPEED
    function automatic step_t sgn_step(input step_t v);
        if (v < 0) begin
            return -SPD;
        end else if (v == 0) begin
            return '0;
        end
        return SPD;
    endfunction

    // Pick axis-aligned or diagonal step from the magnitude ratio
    always_comb begin
        adx    = dx[12] ? (~dx + 13'd1) : dx;
        ady    = dy[12] ? (~dy + 13'd1) : dy;
        step_x = '0;
        step_y = '0;
        if (dx == 0 && dy == 0) begin
            // Aiming at the bow itself: shoot right rather than not at all
            step_x = SPD;
        end else if ({1'b0, adx} >= {ady, 1'b0}) begin
            step_x = sgn_step(dx);
        end else if ({1'b0, ady} >= {adx, 1'b0}) begin
            step_y = sgn_step(dy);
        end else begin
            step_x = sgn_step(dx);
            step_y = sgn_step(dy);
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// Projectile slot pool: fire acceptance with cooldown, per-frame motion,
// screen-bounds kill and target hit counting.
module projectile_pool
    import vga_pkg::*;
#(
    parameter int PROJ_COUNT      = PROJECTILE_COUNT,
    parameter int SPEED           = 6,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int SCREEN_W        = SCREEN_W_DEFAULT,
    parameter int SCREEN_H        = SCREEN_H_DEFAULT,
    parameter int HIT_HALF_W      = 32,
    parameter int HIT_HALF_H      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic                            enable,
    input  logic                            fire,
    input  logic [11:0]                     spawn_x,
    input  logic [11:0]                     spawn_y,
    input  logic [11:0]                     aim_x,
    input  logic [11:0]                     aim_y,
    input  logic                            target_alive,
    input  logic [11:0]                     target_x,
    input  logic [11:0]                     target_y,
    output logic [12*PROJ_COUNT-1:0]        proj_x,
    output logic [12*PROJ_COUNT-1:0]        proj_y,
    output logic [PROJ_COUNT-1:0]           proj_active,
    output logic                            fire_ack,
    output logic                            hit,
    output logic [$clog2(PROJ_COUNT+1)-1:0] hit_num
);

    localparam int HNW  = $clog2(PROJ_COUNT + 1);
    localparam int CDW  = $clog2(COOLDOWN_FRAMES + 2);
    localparam int IDXW = (PROJ_COUNT > 1) ? $clog2(PROJ_COUNT) : 1;

    proj_slot_t             slots [PROJ_COUNT];
    logic                   fire_q;
    logic [CDW-1:0]         cooldown;

    step_t                  dx;
    step_t                  dy;
    step_t                  new_step_x;
    step_t                  new_step_y;

    logic                   free_found;
    logic [IDXW-1:0]        free_idx;
    logic                   accept;

    step_t                  nx [PROJ_COUNT];
    step_t                  ny [PROJ_COUNT];
    logic [PROJ_COUNT-1:0]  strike;
    logic [PROJ_COUNT-1:0]  out_of_bounds;
    logic [HNW-1:0]         hit_count;

    assign dx = {1'b0, aim_x} - {1'b0, spawn_x};
    assign dy = {1'b0, aim_y} - {1'b0, spawn_y};

    proj_aim_quant #(.SPEED(SPEED)) u_aim_quant (
        .dx     (dx),
        .dy     (dy),
        .step_x (new_step_x),
        .step_y (new_step_y)
    );

    // Lowest-index inactive slot; a slot being killed this cycle still counts as busy
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = PROJ_COUNT - 1; i >= 0; i--) begin
            if (!slots[i].active) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    assign accept = fire & ~fire_q & enable & (cooldown == '0) & free_found;

    // Candidate next positions, bounds kill, target strikes and strike count
    always_comb begin
        logic signed [13:0] tdx;
        logic signed [13:0] tdy;
        hit_count = '0;
        for (int i = 0; i < PROJ_COUNT; i++) begin
            nx[i] = {1'b0, slots[i].x} + slots[i].step_x;
            ny[i] = {1'b0, slots[i].y} + slots[i].step_y;
            tdx   = 14'(nx[i]) - 14'({2'b00, target_x});
            tdy   = 14'(ny[i]) - 14'({2'b00, target_y});
            if (tdx < 0) tdx = -tdx;
            if (tdy < 0) tdy = -tdy;
            out_of_bounds[i] = (nx[i] < 0) || (nx[i] >= SCREEN_W) ||
                               (ny[i] < 0) || (ny[i] >= SCREEN_H);
            strike[i] = slots[i].active && target_alive &&
                        (tdx < HIT_HALF_W) && (tdy < HIT_HALF_H);
            if (strike[i]) hit_count = hit_count + HNW'(1);
        end
    end

    // Slot array, cooldown, fire edge register and registered pulses
    // NOTE: async reset in the sensitivity list, and only non-blocking
    // assignments here so every slot sees the pre-edge state of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q   <= 1'b0;
            cooldown <= '0;
            fire_ack <= 1'b0;
            hit      <= 1'b0;
            hit_num  <= '0;
            // NOTE: the slot array is a handful of flops, not RAM, so it is
            // reset like any other state.
            for (int i = 0; i < PROJ_COUNT; i++) slots[i] <= '0;
        end else begin
            fire_q <= fire;
            if (!enable) begin
                cooldown <= '0;
                fire_ack <= 1'b0;
                hit      <= 1'b0;
                hit_num  <= '0;
                for (int i = 0; i < PROJ_COUNT; i++) slots[i] <= '0;
            end else begin
                fire_ack <= accept;
                hit      <= frame_tick && (hit_count != '0);
                hit_num  <= frame_tick ? hit_count : '0;

                if (accept) begin
                    cooldown <= CDW'(COOLDOWN_FRAMES);
                end else if (frame_tick && cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end

                for (int i = 0; i < PROJ_COUNT; i++) begin
                    if (accept && free_idx == IDXW'(i)) begin
                        slots[i] <= '{active: 1'b1, x: spawn_x, y: spawn_y,
                                      step_x: new_step_x, step_y: new_step_y};
                    end else if (frame_tick && slots[i].active) begin
                        if (strike[i] || out_of_bounds[i]) begin
                            slots[i].active <= 1'b0;
                        end else begin
                            slots[i].x <= nx[i][11:0];
                            slots[i].y <= ny[i][11:0];
                        end
                    end
                end
            end
        end
    end

    // Flatten slot state onto the draw-stage buses
    always_comb begin
        proj_x      = '0;
        proj_y      = '0;
        proj_active = '0;
        for (int i = 0; i < PROJ_COUNT; i++) begin
            proj_x[12*i +: 12] = slots[i].x;
            proj_y[12*i +: 12] = slots[i].y;
            proj_active[i]     = slots[i].active;
        end
    end

endmodule
